// File: rtl/olirmathi_ifetch_queue_if.sv
// rtl/olirmathi_ifetch_queue_if.sv - IMEM, redirect and IF/ID bundle for the fetch queue
interface olirmathi_ifetch_queue_if #(
    parameter int AW = 5
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_npc,
        input  imem_ready, imem_rdata, redir_valid, redir_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_npc,
        output imem_ready, imem_rdata, redir_valid, redir_pc, id_ready
    );
endinterface

// File: rtl/olirmathi_ifetch_queue.sv
// rtl/olirmathi_ifetch_queue.sv - instruction fetch with DEPTH-entry IF/ID queue and redirect flush
module olirmathi_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 5,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       RN,
    olirmathi_ifetch_queue_if.master   bus,
    output logic [31:0]                fetch_pc,
    output logic [$clog2(DEPTH):0]     q_count
);
    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;
    logic          inflight_q, inflight_d;
    logic          squash_q, squash_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_ir_q, head_ir_d;
    logic [31:0]   head_npc_q, head_npc_d;
    logic [31:0]   ir_mem_q  [DEPTH];
    logic [31:0]   npc_mem_q [DEPTH];

    logic          issue, accept, push, pop;
    logic [CW:0]   credit;

    always_comb begin
        credit     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        // Credit counts the in-flight read so a returning word always has a free slot.
        issue      = RN & ~bus.redir_valid & (credit < DEPTH_W);
        accept     = issue & bus.imem_ready;
        push       = inflight_q & ~squash_q & ~bus.redir_valid;
        pop        = (count_q != '0) & bus.id_ready & ~bus.redir_valid;

        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        squash_d   = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_ir_d  = head_ir_q;
        head_npc_d = head_npc_q;

        if (bus.redir_valid) begin
            pc_d     = bus.redir_pc;
            squash_d = 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                pc_d  = pc_q + 32'd1;
                tag_d = pc_q;
            end
            inflight_d = accept;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // The head is registered; when the new head is the word being pushed, bypass the array.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_ir_d  = bus.imem_rdata;
                head_npc_d = tag_q + 32'd1;
            end else begin
                head_ir_d  = ir_mem_q[rd_ptr_d];
                head_npc_d = npc_mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RN) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_ir_q  <= '0;
            head_npc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_ir_q  <= head_ir_d;
            head_npc_q <= head_npc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RN && push) begin
            ir_mem_q[wr_ptr_q]  <= bus.imem_rdata;
            npc_mem_q[wr_ptr_q] <= tag_q + 32'd1;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q[AW-1:0];
    assign bus.id_valid  = (count_q != '0);
    assign bus.id_ir     = head_ir_q;
    assign bus.id_npc    = head_npc_q;
    assign fetch_pc      = pc_q;
    assign q_count       = count_q;
endmodule

// File: tb/tb_olirmathi_ifetch_queue.sv
// tb/tb_olirmathi_ifetch_queue.sv - scoreboard bench for the instruction fetch queue
module tb_olirmathi_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;

    logic        clk = 1'b0;
    logic        rn;
    logic [31:0] fetch_pc;
    logic [2:0]  q_count;

    int total  = 0;
    int bad    = 0;
    int n_pops = 0;
    logic [63:0] sb[$];

    olirmathi_ifetch_queue_if #(.AW(AW)) bus ();

    olirmathi_ifetch_queue #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .RESET_PC(32'd0)
    ) u_dut (
        .clk     (clk),
        .RN      (rn),
        .bus     (bus),
        .fetch_pc(fetch_pc),
        .q_count (q_count)
    );

    always #5 clk = ~clk;

    // IMEM[k] = k + 0x100; junk is driven when no read was accepted.
    always @(posedge clk) begin
        if (bus.imem_req && bus.imem_ready)
            bus.imem_rdata <= 32'h100 + 32'(bus.imem_addr);
        else
            bus.imem_rdata <= 32'hBAD0_0000 + $urandom_range(0, 255);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_from(input logic [31:0] pc0);
        logic [31:0] p;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            p = pc0 + 32'(i);
            sb.push_back({32'h100 + (p & 32'd31), p + 32'd1});
        end
    endtask

    always @(negedge clk) begin
        if (rn && !bus.redir_valid && bus.id_valid && bus.id_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got ir=%h npc=%h want none", bus.id_ir, bus.id_npc);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("pop_ir", bus.id_ir, e[63:32]);
                check("pop_npc", bus.id_npc, e[31:0]);
                n_pops++;
            end
        end
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] a;
        logic        rdy;

        rn              = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'd0;
        bus.id_ready    = 1'b0;
        bus.imem_ready  = 1'b1;
        repeat (3) tick();

        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_id_ir", bus.id_ir, 32'd0);
        check("rst_id_npc", bus.id_npc, 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);

        // 1: reset release latency and first stream
        expect_from(32'd0);
        rn           = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        check("t1_req", 32'(bus.imem_req), 32'd1);
        check("t1_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        check("t1_valid_c1", 32'(bus.id_valid), 32'd0);
        tick();
        check("t1_valid_c2", 32'(bus.id_valid), 32'd1);
        check("t1_ir0", bus.id_ir, 32'h100);
        check("t1_npc0", bus.id_npc, 32'd1);
        tick();
        check("t1_ir1", bus.id_ir, 32'h101);
        check("t1_npc1", bus.id_npc, 32'd2);
        tick();
        check("t1_ir2", bus.id_ir, 32'h102);
        check("t1_npc2", bus.id_npc, 32'd3);
        repeat (4) tick();

        // 2: decode stall fills the queue, then drains back-to-back
        rn           = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        expect_from(32'd0);
        rn = 1'b1;
        repeat (10) tick();
        check("t2_q_full", 32'(q_count), 32'd4);
        check("t2_req_off", 32'(bus.imem_req), 32'd0);
        check("t2_head_ir", bus.id_ir, 32'h100);
        check("t2_valid", 32'(bus.id_valid), 32'd1);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t2_stream_valid", 32'(bus.id_valid), 32'd1);
            tick();
        end
        repeat (4) tick();

        // 3: redirect with three queued and one in flight
        rn           = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        expect_from(32'd0);
        rn = 1'b1;
        repeat (4) tick();
        check("t3_q_pre", 32'(q_count), 32'd3);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'd25;
        bus.id_ready    = 1'b1;
        expect_from(32'd25);
        tick();
        bus.redir_valid = 1'b0;
        #1;
        check("t3_valid_off", 32'(bus.id_valid), 32'd0);
        check("t3_q_zero", 32'(q_count), 32'd0);
        check("t3_addr", 32'(bus.imem_addr), 32'd25);
        check("t3_req", 32'(bus.imem_req), 32'd1);
        tick();
        tick();
        check("t3_ir", bus.id_ir, 32'h119);
        check("t3_npc", bus.id_npc, 32'd26);
        repeat (3) tick();

        // 4: redirect with pop, then back-to-back redirects 9 then 3
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'd9;
        expect_from(32'd9);
        tick();
        bus.redir_pc = 32'd3;
        expect_from(32'd3);
        tick();
        bus.redir_valid = 1'b0;
        #1;
        check("t4_q_zero", 32'(q_count), 32'd0);
        check("t4_pc", fetch_pc, 32'd3);
        check("t4_valid_off", 32'(bus.id_valid), 32'd0);
        repeat (8) tick();

        // 5: IMEM ready toggling 1,0,0,1 holds pc while stalled
        pat = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            bus.imem_ready = pat[i % 4];
            #1;
            a   = fetch_pc;
            rdy = bus.imem_ready;
            check("t5_req", 32'(bus.imem_req), 32'd1);
            tick();
            check("t5_pc_step", fetch_pc, a + 32'(rdy));
        end
        bus.imem_ready = 1'b1;
        repeat (6) tick();

        // 6: one-cycle reset mid-stream
        rn = 1'b0;
        expect_from(32'd0);
        tick();
        check("t6_valid", 32'(bus.id_valid), 32'd0);
        check("t6_q", 32'(q_count), 32'd0);
        check("t6_ir", bus.id_ir, 32'd0);
        check("t6_npc", bus.id_npc, 32'd0);
        check("t6_pc", fetch_pc, 32'd0);
        check("t6_req", 32'(bus.imem_req), 32'd0);
        rn = 1'b1;
        tick();
        tick();
        check("t6_restart_ir", bus.id_ir, 32'h100);
        check("t6_restart_npc", bus.id_npc, 32'd1);
        check("t6_restart_valid", 32'(bus.id_valid), 32'd1);
        repeat (6) tick();

        total++;
        if (n_pops < 25) begin
            bad++;
            $display("FAIL pop_count: got %0d want >= 25", n_pops);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
